// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

   // Frame sequencing states of the transmitter.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // Payload bits per frame.
   localparam int unsigned DATA_W_DEFAULT = 8;

   // Short bit period, used for simulation-friendly builds.
   localparam int unsigned CLKS_PER_BIT_SIM = 6;

   // Bit-period divisors for a 100 MHz system clock.
   typedef enum int unsigned {
      CLKS_PER_BIT_9600   = 10417,
      CLKS_PER_BIT_115200 = 868
   } baud_div_e;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   pointer_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan requesters in priority order starting at the pointer.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(pointer_i) + k) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
         end
      end
   end

   assign any_o = found;

endmodule : rr_arbiter

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between NUM_REQ byte producers: round-robin
// arbitration in IDLE, then a start bit, DATA_W data bits LSB first and a
// stop bit, each CLKS_PER_BIT cycles long.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned DATA_W       = DATA_W_DEFAULT,
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_SIM
) (
   input  logic                           CLK,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_serial,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_W);

   tx_state_e          state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [BIT_W-1:0]   bit_q;
   logic [DATA_W-1:0]  shift_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [IDX_W-1:0]   grant_id_q;
   logic               tx_q;
   logic               busy_q;
   logic               bit_end;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i       (req_valid),
      .pointer_i   (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .any_o       (arb_any)
   );

   // Bit-period timing: end of bit on the last count, then wrap to zero.
   assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

   // Next search starts just after the winner.
   assign ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

   // Handshake is offered only while idle and out of reset.
   assign req_ready = (state_q == IDLE && rst_n) ? arb_grant : '0;

   // Frame sequencer with registered line, busy and grant outputs.
   always_ff @(posedge CLK) begin
      // NOTE: reset is sampled on the clock edge (synchronous); all state
      // updates use non-blocking assignments so every register sees the
      // pre-edge values of the others.
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         grant_id_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (arb_any) begin
                  shift_q    <= req_data[arb_idx];
                  grant_id_q <= arb_idx;
                  ptr_q      <= ptr_d;
                  cnt_q      <= '0;
                  bit_q      <= '0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= START;
               end
            end
            START: begin
               cnt_q <= cnt_d;
               if (bit_end) begin
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_d;
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  if (bit_q == BIT_W'(DATA_W - 1)) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                     tx_q  <= shift_q[1];
                  end
               end
            end
            STOP: begin
               cnt_q <= cnt_d;
               if (bit_end) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_serial = tx_q;
   assign busy      = busy_q;
   assign grant_id  = grant_id_q;

endmodule : uart_tx_scheduler

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (NUM_REQ=2, DATA_W=8,
// CLKS_PER_BIT=6). A frame-level model predicts the line every cycle;
// directed scenarios add literal expectations.
module tb_uart_tx_scheduler;

   localparam int NUM_REQ   = 2;
   localparam int DATA_W    = 8;
   localparam int CPB       = 6;
   localparam int FRAME_CYC = (DATA_W + 2) * CPB;

   logic                           CLK = 1'b0;
   logic                           rst_n;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           tx_serial;
   logic                           busy;
   logic [$clog2(NUM_REQ)-1:0]     grant_id;

   uart_tx_scheduler #(
      .NUM_REQ      (NUM_REQ),
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_serial (tx_serial),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 CLK = ~CLK;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- frame-level reference model ----------------
   // Round-robin choice straight from the rule: first valid at or after ptr.
   function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   bit                 m_active = 1'b0;
   int                 m_off    = 0;
   int                 m_ptr    = 0;
   int                 m_gid    = 0;
   logic [DATA_W+1:0]  m_frame  = '1;
   int                 m_pick;

   assign m_pick = pick(req_valid, m_ptr);

   always @(posedge CLK) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_off    <= 0;
         m_ptr    <= 0;
         m_gid    <= 0;
      end else if (m_active) begin
         if (m_off == FRAME_CYC - 1) m_active <= 1'b0;
         m_off <= m_off + 1;
      end else if (m_pick >= 0) begin
         m_active <= 1'b1;
         m_off    <= 0;
         m_frame  <= {1'b1, req_data[m_pick], 1'b0};
         m_gid    <= m_pick;
         m_ptr    <= (m_pick + 1) % NUM_REQ;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge CLK) begin
      logic [NUM_REQ-1:0] exp_rdy;
      logic               exp_tx;
      if (chk_en) begin
         exp_rdy = '0;
         if (!m_active && rst_n && m_pick >= 0) exp_rdy[m_pick] = 1'b1;
         exp_tx = m_active ? m_frame[m_off / CPB] : 1'b1;
         check("model_tx_serial", tx_serial, exp_tx);
         check("model_busy", busy, m_active);
         check("model_req_ready", req_ready, exp_rdy);
         check("model_grant_id", grant_id, m_gid);
      end
   end

   // ---------------- observation helpers ----------------
   int  st_cyc[$];
   int  st_gid[$];
   bit  busy_prev = 1'b0;
   int  rdy0_cnt  = 0;

   always @(negedge CLK) begin
      if (busy && !busy_prev) begin
         st_cyc.push_back(cyc);
         st_gid.push_back(int'(grant_id));
      end
      if (req_ready[0]) rdy0_cnt <= rdy0_cnt + 1;
      busy_prev <= busy;
   end

   task automatic clear_obs();
      st_cyc.delete();
      st_gid.delete();
      rdy0_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      logic [9:0] a5_line;
      int         busy_cnt;

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;

      // Reset held for three cycles.
      @(posedge CLK); #1;
      chk_en = 1'b1;
      tick(2);
      @(negedge CLK);
      check("rst_tx_serial", tx_serial, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_grant_id", grant_id, 0);
      tick(1);
      rst_n = 1'b1;

      // Single byte 0xA5 from requester 0.
      a5_line = 10'b1_1010_0101_0;
      req_data[0] = 8'hA5;
      req_valid   = 2'b01;
      @(negedge CLK);
      check("single_ready", req_ready, 2'b01);
      tick(1);
      req_valid = '0;
      busy_cnt  = 0;
      for (int t = 0; t < FRAME_CYC + 1; t++) begin
         @(negedge CLK);
         if (busy) busy_cnt++;
         if (t < FRAME_CYC && t % CPB == CPB / 2)
            check("single_line_bit", tx_serial, a5_line[t / CPB]);
      end
      check("single_busy_cycles", busy_cnt, FRAME_CYC);
      tick(1);

      // Contention from a fresh reset: grants alternate 0,1,0,1.
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      clear_obs();
      req_data[0] = 8'h11;
      req_data[1] = 8'h22;
      req_valid   = 2'b11;
      tick(190);
      req_valid = '0;
      tick(70);
      check("cont_frames", st_gid.size(), 4);
      if (st_gid.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("cont_grant_seq", st_gid[i], i % 2);
         for (int i = 0; i < 3; i++) check("cont_start_spacing", st_cyc[i+1] - st_cyc[i], 61);
      end

      // Pointer fairness: req1 alone, then both -> req0 next.
      clear_obs();
      req_data[1] = 8'h3C;
      req_valid   = 2'b10;
      tick(1);
      req_data[0] = 8'h5A;
      req_valid   = 2'b11;
      tick(62);
      req_valid = '0;
      tick(65);
      check("fair_frames", st_gid.size(), 2);
      if (st_gid.size() >= 2) begin
         check("fair_first", st_gid[0], 1);
         check("fair_second", st_gid[1], 0);
      end

      // Mid-frame reset at frame cycle 25, then a fresh request.
      clear_obs();
      req_data[0] = 8'hC3;
      req_valid   = 2'b01;
      tick(1);
      req_valid = '0;
      tick(25);
      rst_n = 1'b0;
      @(negedge CLK);
      check("midrst_busy_before", busy, 1'b1);
      tick(1);
      @(negedge CLK);
      check("midrst_tx_serial", tx_serial, 1'b1);
      check("midrst_busy", busy, 1'b0);
      tick(1);
      rst_n = 1'b1;
      clear_obs();
      req_data[1] = 8'h96;
      req_valid   = 2'b10;
      tick(1);
      req_valid = '0;
      tick(65);
      check("midrst_fresh_frames", st_gid.size(), 1);
      if (st_gid.size() >= 1) check("midrst_fresh_gid", st_gid[0], 1);

      // Late arrival: req0 raises valid during a req1 frame.
      clear_obs();
      req_data[1] = 8'h0F;
      req_valid   = 2'b10;
      tick(1);
      req_valid = '0;
      tick(10);
      req_data[0] = 8'hF0;
      req_valid   = 2'b01;
      tick(52);
      req_valid = '0;
      tick(65);
      check("late_frames", st_gid.size(), 2);
      if (st_gid.size() >= 2) begin
         check("late_first", st_gid[0], 1);
         check("late_second", st_gid[1], 0);
         check("late_spacing", st_cyc[1] - st_cyc[0], 61);
      end
      check("late_ready_cycles", rdy0_cnt, 1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_uart_tx_scheduler
